// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/MDWAIT/WB sequencer driving the simple processor datapath.
// Define OVF_RSTATUS_EN to route ALU overflow and multdiv exceptions to $r30 with a status code.
//
// state  | meaning
// FETCH  | load IR from imem
// DECODE | IR fields settle, no enables
// EXEC   | sample overflow, start multdiv
// MEM    | dmem access held MEM_LAT cycles
// MDWAIT | wait for md_ready or timeout
// WB     | regfile write and PC increment
module multicycle_control #(
  parameter int MEM_LAT    = 1,
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_overflow,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [1:0]  rf_wsel,
  output logic [4:0]  alu_op,
  output logic        alu_src_imm,
  output logic        dmem_we,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] rstatus_code,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    MDWAIT = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [7:0] MEM_LAST = 8'(MEM_LAT - 1);
  localparam logic [7:0] MD_LAST  = 8'(MD_TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic        exc;
  logic [31:0] code;
  logic [4:0]  opcode, rd, aluop, wb_waddr;
  logic        is_rtype, is_addi, is_lw, is_sw, is_mul, is_div, is_md;

  assign opcode   = instruction[31:27];
  assign rd       = instruction[26:22];
  assign aluop    = instruction[6:2];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_mul   = is_rtype && (aluop == ALU_MUL);
  assign is_div   = is_rtype && (aluop == ALU_DIV);
  assign is_md    = is_mul || is_div;
  assign wb_waddr = exc ? 5'd30 : rd;

  logic unused_bits;
  assign unused_bits = ^{instruction[21:7], instruction[1:0]};

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // One counter serves both MEM hold and MDWAIT timeout; it is zero on entry to either.
  always_ff @(posedge clock) begin
    if (reset)                                cnt <= '0;
    else if (state == MEM || state == MDWAIT) cnt <= cnt + 8'd1;
    else                                      cnt <= '0;
  end

`ifdef OVF_RSTATUS_EN
  logic is_ovf_op;
  assign is_ovf_op = is_addi || (is_rtype && (aluop == ALU_ADD || aluop == ALU_SUB));

  always_ff @(posedge clock) begin
    if (reset) exc <= 1'b0;
    else begin
      case (state)
        FETCH:   exc <= 1'b0;
        EXEC:    exc <= alu_overflow && is_ovf_op;
        MDWAIT: begin
          if (md_ready)            exc <= md_exception;
          else if (cnt == MD_LAST) exc <= 1'b1;
        end
        default: exc <= exc;
      endcase
    end
  end

  always_comb begin
    code = 32'd1;
    if (is_mul)                 code = 32'd4;
    else if (is_div)            code = 32'd5;
    else if (is_addi)           code = 32'd2;
    else if (aluop == ALU_SUB)  code = 32'd3;
  end
`else
  logic unused_exc_inputs;
  assign unused_exc_inputs = alu_overflow ^ md_exception;
  assign exc  = 1'b0;
  assign code = '0;
`endif

  always_comb begin
    state_next   = state;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wsel      = 2'b00;
    alu_op       = '0;
    alu_src_imm  = 1'b0;
    dmem_we      = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    rstatus_code = '0;
    state_dbg    = 3'd0;
    // Outputs are held at zero for as long as reset is asserted, whatever state it interrupted.
    if (!reset) begin
      state_dbg = state;
      if (state != FETCH) begin
        alu_op      = is_rtype ? aluop : ALU_ADD;
        alu_src_imm = is_addi || is_lw || is_sw;
      end
      case (state)
        FETCH: begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end
        DECODE: state_next = EXEC;
        EXEC: begin
          if (is_md) begin
            md_ctrl_mult = is_mul;
            md_ctrl_div  = is_div;
            state_next   = MDWAIT;
          end
          else if (is_lw || is_sw) state_next = MEM;
          else                     state_next = WB;
        end
        MEM: begin
          dmem_we = is_sw && (cnt == 8'd0);
          if (cnt == MEM_LAST) state_next = WB;
        end
        MDWAIT: if (md_ready || cnt == MD_LAST) state_next = WB;
        WB: begin
          pc_we        = 1'b1;
          rf_waddr     = wb_waddr;
          rf_wsel      = exc ? 2'b11 : is_lw ? 2'b01 : is_md ? 2'b10 : 2'b00;
          rf_we        = (exc || is_rtype || is_addi || is_lw) && (wb_waddr != 5'd0);
          rstatus_code = exc ? code : '0;
          state_next   = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule
